// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter giving two valid/ready masters access to one memory slave.
// Optional hung-slave timeout is built when MEM_BUS_ARBITER_TIMEOUT_EN is defined.
module mem_bus_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_valid,
    output logic            m0_ready,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wstrb,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_valid,
    output logic            m1_ready,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    output logic [DW-1:0]   m1_rdata,
    output logic            s_valid,
    input  logic            s_ready,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wstrb,
    input  logic [DW-1:0]   s_rdata,
    output logic [1:0]      grant,
    output logic            timeout_err
);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;  // 1 = master 1 was the last to complete
    logic   owner_valid;
    logic   timeout_hit;

    if (TIMEOUT == 0) begin : g_timeout_check
        $error("mem_bus_arbiter: TIMEOUT must be nonzero");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (m0_valid && (!m1_valid || last_q)) begin
                    state_d = StOwn0;
                end else if (m1_valid) begin
                    state_d = StOwn1;
                end
            end
            StOwn0, StOwn1: begin
                if (!owner_valid) begin
                    // Owner withdrew before completion: release without crediting it.
                    state_d = StIdle;
                end else if (s_ready || timeout_hit) begin
                    state_d = StIdle;
                    last_d  = (state_q == StOwn1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        grant       = 2'b00;
        owner_valid = 1'b0;
        s_valid     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m0_ready    = 1'b0;
        m0_rdata    = '0;
        m1_ready    = 1'b0;
        m1_rdata    = '0;
        unique case (state_q)
            StOwn0: begin
                grant       = 2'b01;
                owner_valid = m0_valid;
                s_valid     = m0_valid & ~timeout_hit;
                s_addr      = m0_addr;
                s_wdata     = m0_wdata;
                s_wstrb     = m0_wstrb;
                m0_ready    = s_ready | timeout_hit;
                m0_rdata    = timeout_hit ? DW'(32'hDEADBEEF) : s_rdata;
            end
            StOwn1: begin
                grant       = 2'b10;
                owner_valid = m1_valid;
                s_valid     = m1_valid & ~timeout_hit;
                s_addr      = m1_addr;
                s_wdata     = m1_wdata;
                s_wstrb     = m1_wstrb;
                m1_ready    = s_ready | timeout_hit;
                m1_rdata    = timeout_hit ? DW'(32'hDEADBEEF) : s_rdata;
            end
            default: ;
        endcase
    end

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            owned;

    assign owned       = (state_q != StIdle);
    assign timeout_hit = owned && !s_ready && (cnt_q == CntW'(TIMEOUT));
    assign timeout_err = err_q;

    // Held at zero while idle so every grant starts counting from zero.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q | timeout_hit;
        if (!owned) begin
            cnt_d = '0;
        end else if (!s_ready && !timeout_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; covers the timeout path when
// MEM_BUS_ARBITER_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_valid, m0_ready, m1_valid, m1_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  grant;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m0_valid = 1'b1; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
        m1_valid = 1'b1; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        s_ready = 1'b1; s_rdata = 32'hFFFF_FFFF;
        #3;
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rst_grant: got %b want 00", grant); end
        n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rst_s_valid: got %b want 0", s_valid); end
        n_checks++; if (m0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_m0_ready: got %b want 0", m0_ready); end
        n_checks++; if (m0_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_m0_rdata: got %h want 0", m0_rdata); end
        n_checks++; if (m1_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_m1_rdata: got %h want 0", m1_rdata); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_terr: got %b want 0", timeout_err); end
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = 32'h0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        step();
        m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
        #3;
        n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rd_lat_s_valid: got %b want 0", s_valid); end
        step();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        #3;
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rd_grant: got %b want 01", grant); end
        n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL rd_s_valid: got %b want 1", s_valid); end
        n_checks++; if (s_addr !== 32'h100) begin n_fail++; $display("FAIL rd_s_addr: got %h want 100", s_addr); end
        n_checks++; if (m0_ready !== 1'b1) begin n_fail++; $display("FAIL rd_m0_ready: got %b want 1", m0_ready); end
        n_checks++; if (m0_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_m0_rdata: got %h want 12345678", m0_rdata); end
        n_checks++; if (m1_ready !== 1'b0) begin n_fail++; $display("FAIL rd_m1_ready: got %b want 0", m1_ready); end
        n_checks++; if (m1_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_m1_rdata: got %h want 0", m1_rdata); end
        step();
        m0_valid = 1'b0; s_ready = 1'b0;
        #3;
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rd_release: got %b want 00", grant); end
    endtask

    task automatic test_contention();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m0_valid = 1'b1; m0_addr = 32'h200; m0_wstrb = 4'h0;
        m1_valid = 1'b1; m1_addr = 32'h8_0000; m1_wdata = 32'hA5; m1_wstrb = 4'b0001;
        step();
        s_ready = 1'b1;
        #3;
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL ct_first: got %b want 01", grant); end
        n_checks++; if (s_addr !== 32'h200) begin n_fail++; $display("FAIL ct_m0_addr: got %h want 200", s_addr); end
        n_checks++; if (m1_ready !== 1'b0) begin n_fail++; $display("FAIL ct_m1_wait: got %b want 0", m1_ready); end
        step();
        m0_valid = 1'b0; s_ready = 1'b0;
        #3;
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL ct_idle: got %b want 00", grant); end
        step();
        s_ready = 1'b1;
        #3;
        n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL ct_second: got %b want 10", grant); end
        n_checks++; if (s_addr !== 32'h8_0000) begin n_fail++; $display("FAIL ct_m1_addr: got %h want 80000", s_addr); end
        n_checks++; if (s_wdata !== 32'hA5) begin n_fail++; $display("FAIL ct_wdata: got %h want a5", s_wdata); end
        n_checks++; if (s_wstrb !== 4'b0001) begin n_fail++; $display("FAIL ct_wstrb: got %b want 0001", s_wstrb); end
        n_checks++; if (m1_ready !== 1'b1) begin n_fail++; $display("FAIL ct_m1_ready: got %b want 1", m1_ready); end
        n_checks++; if (m0_ready !== 1'b0) begin n_fail++; $display("FAIL ct_m0_nonowner: got %b want 0", m0_ready); end
        step();
        m1_valid = 1'b0; s_ready = 1'b0;
        #3;
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL ct_end: got %b want 00", grant); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp;
        m0_valid = 1'b1; m0_addr = 32'h10;
        m1_valid = 1'b1; m1_addr = 32'h20;
        s_ready = 1'b1; s_rdata = 32'h0;
        #3;
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL b2b_start: got %b want 00", grant); end
        for (int k = 0; k < 12; k++) begin
            step();
            #3;
            exp = (k % 2 == 1) ? 2'b00 : ((k % 4 == 0) ? 2'b01 : 2'b10);
            n_checks++; if (grant !== exp) begin n_fail++; $display("FAIL b2b_cycle%0d: got %b want %b", k, grant, exp); end
            if (k == 11) begin
                m0_valid = 1'b0; m1_valid = 1'b0;
            end
        end
        s_ready = 1'b0;
    endtask

    task automatic test_stall();
        step();
        m1_valid = 1'b1; m1_addr = 32'h300;
        #3;
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL st_idle: got %b want 00", grant); end
        step();
        m0_valid = 1'b1; m0_addr = 32'h400; s_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #3;
            n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL st_hold%0d: got %b want 10", i, grant); end
            n_checks++; if (m0_ready !== 1'b0) begin n_fail++; $display("FAIL st_m0_ready%0d: got %b want 0", i, m0_ready); end
            n_checks++; if (s_addr !== 32'h300) begin n_fail++; $display("FAIL st_addr%0d: got %h want 300", i, s_addr); end
            step();
        end
        s_ready = 1'b1;
        #3;
        n_checks++; if (m1_ready !== 1'b1) begin n_fail++; $display("FAIL st_m1_done: got %b want 1", m1_ready); end
        n_checks++; if (m0_ready !== 1'b0) begin n_fail++; $display("FAIL st_m0_done: got %b want 0", m0_ready); end
        step();
        m1_valid = 1'b0; s_ready = 1'b0;
        #3;
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL st_gap: got %b want 00", grant); end
        step();
        s_ready = 1'b1; s_rdata = 32'hCAFE_0001;
        #3;
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL st_m0_grant: got %b want 01", grant); end
        n_checks++; if (s_addr !== 32'h400) begin n_fail++; $display("FAIL st_m0_addr: got %h want 400", s_addr); end
        n_checks++; if (m0_rdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL st_m0_rdata: got %h want cafe0001", m0_rdata); end
        step();
        m0_valid = 1'b0; s_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        step();
        m0_valid = 1'b1; m0_addr = 32'h500;
        step();
        #3;
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rm_own: got %b want 01", grant); end
        s_ready = 1'b1; s_rdata = 32'h55;
        rst_n = 1'b0;
        #1;
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rm_grant: got %b want 00", grant); end
        n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rm_s_valid: got %b want 0", s_valid); end
        n_checks++; if (s_addr !== 32'h0) begin n_fail++; $display("FAIL rm_s_addr: got %h want 0", s_addr); end
        n_checks++; if (m0_ready !== 1'b0) begin n_fail++; $display("FAIL rm_m0_ready: got %b want 0", m0_ready); end
        n_checks++; if (m0_rdata !== 32'h0) begin n_fail++; $display("FAIL rm_m0_rdata: got %h want 0", m0_rdata); end
        m1_valid = 1'b1; m1_addr = 32'h600;
        #2;
        rst_n = 1'b1;
        step();
        #3;
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rm_first: got %b want 01", grant); end
        step();
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
    endtask

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        step();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m0_valid = 1'b1; m0_addr = 32'h700; s_ready = 1'b0; s_rdata = 32'h0;
        step();
        for (int k = 0; k < 16; k++) begin
            #3;
            n_checks++; if (m0_ready !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d: got %b want 0", k, m0_ready); end
            step();
        end
        #3;
        n_checks++; if (m0_ready !== 1'b1) begin n_fail++; $display("FAIL to_ready: got %b want 1", m0_ready); end
        n_checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_rdata: got %h want deadbeef", m0_rdata); end
        n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL to_s_valid: got %b want 0", s_valid); end
        step();
        m0_valid = 1'b0;
        #3;
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL to_idle: got %b want 00", grant); end
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", timeout_err); end
        step();
        step();
        #3;
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
    endtask
`else
    task automatic test_timeout();
        step();
        m0_valid = 1'b1; m0_addr = 32'h700; s_ready = 1'b0;
        for (int k = 0; k < 20; k++) step();
        #3;
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL to_stall: got %b want 01", grant); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_err: got %b want 0", timeout_err); end
        m0_valid = 1'b0;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
